// File: rtl/hazard_stall_unit.sv
// Hazard stall unit: holds PC and IF/ID and bubbles ID/EX until a producer's result is forwardable.
// Define HAZARD_BRANCH_ID_EN for ID-resolved branches (branch hazard rules, HOLD state, taken-branch flush).
module hazard_stall_unit #(
    parameter int CNT_W = 16
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic [4:0]       IFIDRs,
    input  logic [4:0]       IFIDRt,
    input  logic             IFIDUsesRs,
    input  logic             IFIDUsesRt,
    input  logic             IFIDBranch,
    input  logic             BranchTaken,
    input  logic             IDEXMemRead,
    input  logic             IDEXRegWrite,
    input  logic [4:0]       IDEXRd,
    input  logic             EXMEMMemRead,
    input  logic [4:0]       EXMEMRd,
    input  logic             Flush,
    output logic             PCWrite,
    output logic             IFIDWrite,
    output logic             IDEXBubble,
    output logic             IFIDFlush,
    output logic             Stalled,
    output logic [CNT_W-1:0] StallCycles
);

    function automatic logic src_match(input logic [4:0] r, input logic [4:0] rs,
                                       input logic [4:0] rt, input logic use_rs,
                                       input logic use_rt);
        return (r != 5'd0) && (((r == rs) && use_rs) || ((r == rt) && use_rt));
    endfunction

    logic             w_match_ex;
    logic [1:0]       w_need;
    logic             w_stalled;
    logic [CNT_W-1:0] r_cnt;

    assign w_match_ex = src_match(IDEXRd, IFIDRs, IFIDRt, IFIDUsesRs, IFIDUsesRt);

`ifdef HAZARD_BRANCH_ID_EN
    typedef enum logic {ST_RUN, ST_HOLD} state_t;

    state_t r_state;
    logic   w_match_mem;

    assign w_match_mem = src_match(EXMEMRd, IFIDRs, IFIDRt, IFIDUsesRs, IFIDUsesRt);

    // First matching rule wins; a load feeding a branch needs two cycles.
    always_comb begin
        w_need = 2'd0;
        if (IFIDBranch && IDEXMemRead && w_match_ex)
            w_need = 2'd2;
        else if (IDEXMemRead && w_match_ex)
            w_need = 2'd1;
        else if (IFIDBranch && IDEXRegWrite && w_match_ex)
            w_need = 2'd1;
        else if (IFIDBranch && EXMEMMemRead && w_match_mem)
            w_need = 2'd1;
    end

    // Rst gates the stall so outputs fall to non-stall values the moment reset asserts.
    assign w_stalled = Rst && !Flush && ((r_state == ST_HOLD) || (w_need != 2'd0));
    assign IFIDFlush = Flush || (IFIDBranch && BranchTaken && !w_stalled);

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_state <= ST_RUN;
        end else if (Flush) begin
            r_state <= ST_RUN;
        end else begin
            case (r_state)
                ST_RUN:  r_state <= (w_need == 2'd2) ? ST_HOLD : ST_RUN;
                ST_HOLD: r_state <= ST_RUN;
                default: r_state <= ST_RUN;
            endcase
        end
    end
`else
    logic w_unused_branch;

    assign w_unused_branch = ^{IFIDBranch, BranchTaken, IDEXRegWrite, EXMEMMemRead, EXMEMRd};
    assign w_need          = {1'b0, IDEXMemRead && w_match_ex};
    assign w_stalled       = Rst && !Flush && w_need[0];
    assign IFIDFlush       = Flush;
`endif

    assign Stalled     = w_stalled;
    assign PCWrite     = !w_stalled;
    assign IFIDWrite   = !w_stalled;
    assign IDEXBubble  = w_stalled;
    assign StallCycles = r_cnt;

    // Saturating performance counter.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst)
            r_cnt <= '0;
        else if (w_stalled && (r_cnt != {CNT_W{1'b1}}))
            r_cnt <= r_cnt + 1'b1;
    end

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Scoreboard bench for hazard_stall_unit: directed scenarios plus randomized traffic against a rule-level model.
module tb_hazard_stall_unit;

    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             Clk, Rst;
    logic [4:0]       IFIDRs, IFIDRt, IDEXRd, EXMEMRd;
    logic             IFIDUsesRs, IFIDUsesRt, IFIDBranch, BranchTaken;
    logic             IDEXMemRead, IDEXRegWrite, EXMEMMemRead, Flush;
    logic             PCWrite, IFIDWrite, IDEXBubble, IFIDFlush, Stalled;
    logic [CNT_W-1:0] StallCycles;

    hazard_stall_unit #(.CNT_W(CNT_W)) dut (
        .Clk(Clk), .Rst(Rst),
        .IFIDRs(IFIDRs), .IFIDRt(IFIDRt),
        .IFIDUsesRs(IFIDUsesRs), .IFIDUsesRt(IFIDUsesRt),
        .IFIDBranch(IFIDBranch), .BranchTaken(BranchTaken),
        .IDEXMemRead(IDEXMemRead), .IDEXRegWrite(IDEXRegWrite), .IDEXRd(IDEXRd),
        .EXMEMMemRead(EXMEMMemRead), .EXMEMRd(EXMEMRd), .Flush(Flush),
        .PCWrite(PCWrite), .IFIDWrite(IFIDWrite), .IDEXBubble(IDEXBubble),
        .IFIDFlush(IFIDFlush), .Stalled(Stalled), .StallCycles(StallCycles)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct packed {
        logic             pcw;
        logic             ifw;
        logic             bub;
        logic             ifl;
        logic             stl;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    exp_t sb[$];
    event ev_smp;
    int   checks = 0;
    int   errors = 0;

    // Model state: forced stall cycles still owed, stall count, last evaluated demand.
    int   m_hold = 0;
    int   m_cnt  = 0;
    int   m_n    = 0;
    bit   m_stl  = 0;

    function automatic bit m_match(input logic [4:0] r);
        return (r != 0) && ((r == IFIDRs && IFIDUsesRs) || (r == IFIDRt && IFIDUsesRt));
    endfunction

    function automatic int m_demand();
`ifdef HAZARD_BRANCH_ID_EN
        if (IFIDBranch && IDEXMemRead && m_match(IDEXRd)) return 2;
        if (IDEXMemRead && m_match(IDEXRd)) return 1;
        if (IFIDBranch && IDEXRegWrite && m_match(IDEXRd)) return 1;
        if (IFIDBranch && EXMEMMemRead && m_match(EXMEMRd)) return 1;
        return 0;
`else
        return (IDEXMemRead && m_match(IDEXRd)) ? 1 : 0;
`endif
    endfunction

    function automatic exp_t model_eval();
        exp_t e;
        m_n = 0;
        if (!Rst || Flush)    m_stl = 0;
        else if (m_hold > 0)  m_stl = 1;
        else begin
            m_n   = m_demand();
            m_stl = (m_n > 0);
        end
        e.stl = m_stl;
        e.pcw = !m_stl;
        e.ifw = !m_stl;
        e.bub = m_stl;
`ifdef HAZARD_BRANCH_ID_EN
        e.ifl = Flush || (IFIDBranch && BranchTaken && !m_stl);
`else
        e.ifl = Flush;
`endif
        e.cnt = m_cnt[CNT_W-1:0];
        return e;
    endfunction

    function automatic void model_edge();
        if (Rst) begin
            if (m_stl) m_cnt = (m_cnt >= CNT_MAX) ? CNT_MAX : m_cnt + 1;
            if (Flush)           m_hold = 0;
            else if (m_hold > 0) m_hold = m_hold - 1;
            else if (m_n == 2)   m_hold = 1;
        end
    endfunction

    task automatic apply();
        if (!Rst) begin
            m_hold = 0;
            m_cnt  = 0;
        end
        sb.push_back(model_eval());
        -> ev_smp;
        #2;
    endtask

    task automatic end_cycle();
        apply();
        @(posedge Clk);
        model_edge();
    endtask

    task automatic clr_in();
        IFIDRs = 0; IFIDRt = 0; IDEXRd = 0; EXMEMRd = 0;
        IFIDUsesRs = 0; IFIDUsesRt = 0; IFIDBranch = 0; BranchTaken = 0;
        IDEXMemRead = 0; IDEXRegWrite = 0; EXMEMMemRead = 0; Flush = 0;
    endtask

    task automatic rnd_in();
        IFIDRs       = 5'($urandom_range(0, 3));
        IFIDRt       = 5'($urandom_range(0, 3));
        IDEXRd       = 5'($urandom_range(0, 3));
        EXMEMRd      = 5'($urandom_range(0, 3));
        IFIDUsesRs   = 1'($urandom_range(0, 1));
        IFIDUsesRt   = 1'($urandom_range(0, 1));
        IFIDBranch   = 1'($urandom_range(0, 1));
        BranchTaken  = 1'($urandom_range(0, 1));
        IDEXMemRead  = 1'($urandom_range(0, 1));
        IDEXRegWrite = 1'($urandom_range(0, 1));
        EXMEMMemRead = 1'($urandom_range(0, 1));
        Flush        = ($urandom_range(0, 7) == 0);
    endtask

    task automatic branch_load_in();
        clr_in();
        IFIDBranch = 1; IDEXMemRead = 1; IDEXRd = 8; IFIDRt = 8; IFIDUsesRt = 1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Monitor: pops one expectation per presented sample.
    initial begin
        exp_t e;
        forever begin
            @(ev_smp);
            #1;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard_underflow at %0t: got 0 entries expected 1", $time);
            end else begin
                e = sb.pop_front();
                chk("PCWrite",     int'(PCWrite),     int'(e.pcw));
                chk("IFIDWrite",   int'(IFIDWrite),   int'(e.ifw));
                chk("IDEXBubble",  int'(IDEXBubble),  int'(e.bub));
                chk("IFIDFlush",   int'(IFIDFlush),   int'(e.ifl));
                chk("Stalled",     int'(Stalled),     int'(e.stl));
                chk("StallCycles", int'(StallCycles), int'(e.cnt));
            end
        end
    end

    initial begin
        clr_in();
        Rst = 0;
        // Reset state, including a hazard presented while reset is held.
        @(negedge Clk); end_cycle();
        @(negedge Clk); IDEXMemRead = 1; IDEXRd = 5; IFIDRs = 5; IFIDUsesRs = 1; end_cycle();
        @(negedge Clk); Rst = 1; clr_in(); end_cycle();

        // Load-use: one stall, then clear with count 1.
        @(negedge Clk); IDEXMemRead = 1; IDEXRd = 5; IFIDRs = 5; IFIDUsesRs = 1; end_cycle();
        @(negedge Clk); IDEXMemRead = 0; end_cycle();

        // Branch after load: two stalls, then taken branch flushes.
        @(negedge Clk); branch_load_in(); end_cycle();
        @(negedge Clk); end_cycle();
        @(negedge Clk); IDEXMemRead = 0; BranchTaken = 1; end_cycle();

        // Register zero never stalls.
        @(negedge Clk); clr_in(); IDEXMemRead = 1; IFIDUsesRs = 1; IFIDBranch = 1; IDEXRegWrite = 1; end_cycle();

        // Abort HOLD with Flush, then a clean cycle.
        @(negedge Clk); branch_load_in(); end_cycle();
        @(negedge Clk); Flush = 1; end_cycle();
        @(negedge Clk); clr_in(); end_cycle();

        // Reset mid-HOLD: stall seen, then reset drops it within the same low phase.
        @(negedge Clk); branch_load_in(); end_cycle();
        @(negedge Clk); apply(); Rst = 0; end_cycle();
        @(negedge Clk); Rst = 1; clr_in(); end_cycle();

        // Reset and Flush together with a hazard.
        @(negedge Clk); Rst = 0; Flush = 1; IDEXMemRead = 1; IDEXRd = 3; IFIDRt = 3; IFIDUsesRt = 1; end_cycle();
        @(negedge Clk); Rst = 1; clr_in(); end_cycle();

        // Hazard together with taken branch: stall wins.
        @(negedge Clk); IFIDBranch = 1; BranchTaken = 1; IDEXRegWrite = 1; IDEXRd = 2; IFIDRs = 2; IFIDUsesRs = 1; end_cycle();
        @(negedge Clk); clr_in(); EXMEMMemRead = 1; EXMEMRd = 4; IFIDRt = 4; IFIDUsesRt = 1; IFIDBranch = 1; BranchTaken = 1; end_cycle();

        // Saturation: load-use held for 20 cycles.
        @(negedge Clk); clr_in(); IDEXMemRead = 1; IDEXRd = 7; IFIDRs = 7; IFIDUsesRs = 1;
        for (int i = 0; i < 20; i++) begin
            if (i > 0) @(negedge Clk);
            end_cycle();
        end
        @(negedge Clk); IDEXMemRead = 0; end_cycle();

        // Restart the counter and run randomized traffic with occasional resets.
        @(negedge Clk); Rst = 0; end_cycle();
        @(negedge Clk); Rst = 1; end_cycle();
        for (int i = 0; i < 400; i++) begin
            @(negedge Clk);
            rnd_in();
            Rst = ($urandom_range(0, 63) != 0);
            end_cycle();
        end

        for (int i = 0; i < 20 && sb.size() != 0; i++) #1;
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_stall_unit.md
# hazard_stall_unit

Producer-side complement to the forwarding unit: it detects hazards that forwarding cannot cover and holds the front of the pipeline until the producing instruction's result becomes forwardable. It sits beside the ID stage. It drives the PC and IF/ID write enables, the ID/EX bubble select and the IF/ID flush. It also keeps a saturating stall-cycle counter for performance measurement.

## Interface
- `CNT_W`, 16, width of the stall-cycle performance counter.
- `Clk`  in  1  pipeline clock; all state updates on the rising edge.
- `Rst`  in  1  asynchronous, active-low reset.
- `IFIDRs`, `IFIDRt`  in  5 each  source registers of the instruction in ID.
- `IFIDUsesRs`, `IFIDUsesRt`  in  1 each  the ID instruction actually reads that source.
- `IFIDBranch`  in  1  the ID instruction is a conditional branch resolved in ID.
- `BranchTaken`  in  1  the ID comparator result for that branch.
- `IDEXMemRead`, `IDEXRegWrite`  in  1 each  control bits of the instruction in EX.
- `IDEXRd`  in  5  destination register of the instruction in EX.
- `EXMEMMemRead`  in  1  the instruction in MEM is a load.
- `EXMEMRd`  in  5  destination register of the instruction in MEM.
- `Flush`  in  1  a later stage is squashing ID (jump or exception).
- `PCWrite`  out  1  1 = PC advances.
- `IFIDWrite`  out  1  1 = IF/ID register loads.
- `IDEXBubble`  out  1  1 = ID/EX receives all-zero control.
- `IFIDFlush`  out  1  1 = IF/ID is cleared to a NOP on the next edge.
- `Stalled`  out  1  a stall is asserted this cycle.
- `StallCycles`  out  CNT_W  count of stall cycles since reset; saturates at all-ones.

## Operation
- Source match `M(r)`: `r != 0` and (`r == IFIDRs && IFIDUsesRs` or `r == IFIDRt && IFIDUsesRt`).
- Stall demand `N` is evaluated in RUN only. The first matching rule below wins:
  - Branch in ID, load in EX: `IFIDBranch && IDEXMemRead && M(IDEXRd)` gives N=2.
  - Load-use: `IDEXMemRead && M(IDEXRd)` gives N=1.
  - Branch in ID, ALU result in EX: `IFIDBranch && IDEXRegWrite && M(IDEXRd)` gives N=1.
  - Branch in ID, load in MEM: `IFIDBranch && EXMEMMemRead && M(EXMEMRd)` gives N=1.
  - Otherwise N=0.
- FSM has two states, RUN and HOLD.
  - RUN with N=0: no stall, stay in RUN.
  - RUN with N=1: stall this cycle, stay in RUN. The next cycle re-evaluates with the bubble in EX.
  - RUN with N=2: stall this cycle, go to HOLD.
  - HOLD: stall unconditionally for one cycle, then return to RUN.
- Stall cycle outputs: `PCWrite=0`, `IFIDWrite=0`, `IDEXBubble=1`, `Stalled=1`, `IFIDFlush=0`.
- Non-stall cycle outputs: `PCWrite=1`, `IFIDWrite=1`, `IDEXBubble=0`, `Stalled=0`.
- `IFIDFlush = IFIDBranch && BranchTaken && !Stalled`. A branch is never taken while its operands are stale.
- `Flush` overrides everything in the same cycle:
  - Outputs take the non-stall values with `IFIDFlush=1`.
  - `N` is ignored.
  - HOLD is aborted and the next state is RUN.
  - The counter does not increment.
- `StallCycles` increments on every edge where `Stalled=1`. At all-ones it holds its value.

## Timing
- Stall and flush outputs are combinational from the current state and inputs, with zero-cycle latency.
- State and counter are registered.
- Reset (`Rst`=0, asynchronous, any time including mid-HOLD):
  - State goes to RUN and `StallCycles` to 0.
  - Outputs immediately take the non-stall values with `IFIDFlush` driven by its equation.
  - The first edge after reset release evaluates normally.
- Simultaneous `Flush` and reset: reset wins.
- Simultaneous hazard and taken branch: stall wins and `IFIDFlush=0`.
- Register 0 never causes a stall, whatever the control bits.

## Configuration
- `HAZARD_BRANCH_ID_EN`, when defined: branches resolve in ID, so all four rules, HOLD and the `IFIDFlush` equation are active.
- When not defined:
  - Only the load-use rule exists and HOLD is unreachable, so it is not generated.
  - `IFIDBranch` and `BranchTaken` are ignored.
  - `IFIDFlush = Flush`.
  - `Flush` still suppresses stalls and counter increments.

## Test plan
- Load-use: `IDEXMemRead=1`, `IDEXRd=5`, `IFIDRs=5`, `IFIDUsesRs=1`.
  - Exactly one cycle of `PCWrite=0`, `IDEXBubble=1`.
  - Next cycle, with `IDEXMemRead=0`: no stall, and `StallCycles=1`.
- Branch after load (macro on): `IFIDBranch=1`, `IDEXMemRead=1`, `IDEXRd=8`, `IFIDRt=8`.
  - Two consecutive stall cycles, with the FSM passing through HOLD, and `IFIDFlush=0` throughout.
  - The following cycle with `BranchTaken=1` gives `IFIDFlush=1`.
- Register zero: `IDEXMemRead=1`, `IDEXRd=0`, `IFIDRs=0`.
  - No stall and the counter stays 0.
- Abort in HOLD: enter HOLD as above, then assert `Flush` in the HOLD cycle.
  - That cycle: `Stalled=0`, `IFIDFlush=1`.
  - Next state is RUN.
  - Counter advances by 1 only.
- Reset mid-HOLD: pull `Rst` low between edges while in HOLD.
  - Outputs drop to non-stall values immediately, and `StallCycles=0`.
  - After release, a hazard-free input gives no stall.
- Saturation with `CNT_W=4`: hold a load-use hazard for 20 cycles.
  - `StallCycles` reaches 15 and stays at 15.
